// File: rtl/cr_huf_comp_st_serializer.sv
// Symbol-table serializer: walks a completed symbol table entry by entry,
// emits one beat per valid entry on a valid/ready output, then closes the
// table with a terminator beat carrying the extra-bit total and an error
// flag, and finally pulses sa_st_read_done to release the upstream buffer.

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module cr_huf_comp_st_serializer #(
   parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
   parameter int PTR_WIDTH              = 10,
   parameter int SYM_WIDTH              = 5,
   parameter int XTR_SIZE_WIDTH         = 14
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              sym_buf_full,
   input  logic [PTR_WIDTH-1:0]              sym_buf_wr_ptr,
   input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0] sym_buf_val,
   input  logic [SYM_WIDTH-1:0]              sym_buf_symbol       [MAX_SYMBOL_TABLE_DEPTH],
   input  logic [7:0]                        sym_buf_extra        [MAX_SYMBOL_TABLE_DEPTH],
   input  logic [3:0]                        sym_buf_extra_length [MAX_SYMBOL_TABLE_DEPTH],
   input  logic [XTR_SIZE_WIDTH-1:0]         st_extra_size_store,
   input  logic                              st_build_error,
   input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] st_seq_id,
   output logic                              sa_st_read_done,
   output logic                              out_vld,
   input  logic                              out_rdy,
   output logic [SYM_WIDTH-1:0]              out_symbol,
   output logic [7:0]                        out_extra,
   output logic [3:0]                        out_extra_length,
   output logic                              out_last,
   output logic                              out_err,
   output logic [XTR_SIZE_WIDTH-1:0]         out_xtr_total,
   output logic [`CREOLE_HC_SEQID_WIDTH-1:0] out_seq_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      TERM = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(MAX_SYMBOL_TABLE_DEPTH);
   localparam logic [PTR_WIDTH-1:0] ONE_P   = PTR_WIDTH'(1);

   state_t                              state_q, state_d;
   logic [PTR_WIDTH-1:0]                rd_ptr_q, rd_ptr_d;
   logic [XTR_SIZE_WIDTH-1:0]           acc_q, acc_d;
   logic                                out_vld_q, out_vld_d;
   logic [SYM_WIDTH-1:0]                out_symbol_q, out_symbol_d;
   logic [7:0]                          out_extra_q, out_extra_d;
   logic [3:0]                          out_extra_length_q, out_extra_length_d;
   logic                                out_last_q, out_last_d;
   logic                                out_err_q, out_err_d;
   logic [XTR_SIZE_WIDTH-1:0]           out_xtr_total_q, out_xtr_total_d;
   logic [`CREOLE_HC_SEQID_WIDTH-1:0]   out_seq_id_q, out_seq_id_d;
   logic                                read_done_q, read_done_d;

   logic [PTR_WIDTH-1:0]                n_clamped;
   logic                                out_free;

   // Entry count limited to the physical table size; the output register
   // can take a new beat when empty or when its current beat is leaving.
   assign n_clamped = (sym_buf_wr_ptr > DEPTH_P) ? DEPTH_P : sym_buf_wr_ptr;
   assign out_free  = !out_vld_q || out_rdy;

   // Next-state, scan pointer, accumulator and output-register loading.
   always_comb begin
      state_d            = state_q;
      rd_ptr_d           = rd_ptr_q;
      acc_d              = acc_q;
      out_vld_d          = out_vld_q;
      out_symbol_d       = out_symbol_q;
      out_extra_d        = out_extra_q;
      out_extra_length_d = out_extra_length_q;
      out_last_d         = out_last_q;
      out_err_d          = out_err_q;
      out_xtr_total_d    = out_xtr_total_q;
      out_seq_id_d       = out_seq_id_q;
      read_done_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (sym_buf_full) begin
               rd_ptr_d     = '0;
               acc_d        = '0;
               out_seq_id_d = st_seq_id;
               // A failed build or an empty table has nothing to scan.
               if (st_build_error || (n_clamped == '0)) begin
                  state_d = TERM;
               end else begin
                  state_d = SCAN;
               end
            end
         end

         SCAN: begin
            if (out_free) begin
               rd_ptr_d = rd_ptr_q + ONE_P;
               if (sym_buf_val[rd_ptr_q]) begin
                  out_vld_d          = 1'b1;
                  out_symbol_d       = sym_buf_symbol[rd_ptr_q];
                  out_extra_d        = sym_buf_extra[rd_ptr_q];
                  out_extra_length_d = sym_buf_extra_length[rd_ptr_q];
                  out_last_d         = 1'b0;
                  out_err_d          = 1'b0;
                  out_xtr_total_d    = '0;
                  acc_d              = acc_q + XTR_SIZE_WIDTH'(sym_buf_extra_length[rd_ptr_q]);
               end else begin
                  // Invalid entries burn a cycle but produce no beat.
                  out_vld_d = 1'b0;
               end
               if (rd_ptr_q == (n_clamped - ONE_P)) begin
                  state_d = TERM;
               end
            end
         end

         TERM: begin
            if (out_vld_q && out_last_q) begin
               // Terminator already presented: wait for it to be taken.
               if (out_rdy) begin
                  out_vld_d   = 1'b0;
                  out_last_d  = 1'b0;
                  read_done_d = 1'b1;
                  state_d     = DONE;
               end
            end else if (out_free) begin
               out_vld_d          = 1'b1;
               out_symbol_d       = '0;
               out_extra_d        = '0;
               out_extra_length_d = '0;
               out_last_d         = 1'b1;
               out_err_d          = st_build_error || (acc_q != st_extra_size_store);
               out_xtr_total_d    = acc_q;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q            <= IDLE;
         rd_ptr_q           <= '0;
         acc_q              <= '0;
         out_vld_q          <= 1'b0;
         out_symbol_q       <= '0;
         out_extra_q        <= '0;
         out_extra_length_q <= '0;
         out_last_q         <= 1'b0;
         out_err_q          <= 1'b0;
         out_xtr_total_q    <= '0;
         out_seq_id_q       <= '0;
         read_done_q        <= 1'b0;
      end else begin
         state_q            <= state_d;
         rd_ptr_q           <= rd_ptr_d;
         acc_q              <= acc_d;
         out_vld_q          <= out_vld_d;
         out_symbol_q       <= out_symbol_d;
         out_extra_q        <= out_extra_d;
         out_extra_length_q <= out_extra_length_d;
         out_last_q         <= out_last_d;
         out_err_q          <= out_err_d;
         out_xtr_total_q    <= out_xtr_total_d;
         out_seq_id_q       <= out_seq_id_d;
         read_done_q        <= read_done_d;
      end
   end

   assign sa_st_read_done  = read_done_q;
   assign out_vld          = out_vld_q;
   assign out_symbol       = out_symbol_q;
   assign out_extra        = out_extra_q;
   assign out_extra_length = out_extra_length_q;
   assign out_last         = out_last_q;
   assign out_err          = out_err_q;
   assign out_xtr_total    = out_xtr_total_q;
   assign out_seq_id       = out_seq_id_q;

endmodule
